execute_muldiv: RTL

Parametrised iterative multiply/divide unit for the execute stage, implementing the RV64M operations and their W variants. It sits beside the single-cycle ALU: the execute stage issues M-extension ops through a valid/ready handshake and stalls the pipeline until the result is accepted. The unit is multi-cycle and holds state, with configurable datapath width and bits retired per cycle.

---
 rtl/execute_muldiv_pkg.sv | 46 ++++
 rtl/execute_muldiv_divstep.sv | 37 +++
 rtl/execute_muldiv.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/execute_muldiv_pkg.sv
// Shared types and helpers for the iterative execute-stage multiply/divide unit.
package execute_muldiv_pkg;

    localparam int WORD_BITS = 32;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_DONE
    } muldiv_state_t;

    // Per-op control latched at accept; neg is the sign of the selected result.
    typedef struct packed {
        muldiv_op_t op;
        logic       word;
        logic       neg;
    } muldiv_ctrl_t;

    function automatic logic op_is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input muldiv_op_t op);
        return op inside {MD_REM, MD_REMU};
    endfunction

    function automatic logic src1_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic src2_signed(input muldiv_op_t op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/execute_muldiv_divstep.sv
// Restoring division step retiring STEP_BITS quotient bits per call.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module execute_muldiv_divstep #(
    parameter int XLEN      = 64,
    parameter int STEP_BITS = 1
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN-1:0] r;
    logic [XLEN-1:0] q;
    logic [XLEN:0]   trial;

    // quo_in carries the unconsumed dividend in its upper bits; quotient bits enter at bit 0.
    always_comb begin
        r     = rem_in;
        q     = quo_in;
        trial = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            trial = {r, q[XLEN-1]};
            q     = {q[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, divisor}) begin
                trial = trial - {1'b0, divisor};
                q[0]  = 1'b1;
            end
            r = trial[XLEN-1:0];
        end
        rem_out = r;
        quo_out = q;
    end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative RV64M multiply/divide unit with W variants.
// Latency: W/STEP_BITS cycles to out_valid; divide-by-zero and signed overflow in 1 cycle.
// Backpressure: result held in DONE until out_ready; in_ready low while busy or flushing.
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int STEP_BITS = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_op_t      op,
    input  logic            word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN / STEP_BITS + 1);
    localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    muldiv_state_t   state_q;
    muldiv_ctrl_t    ctrl_q, ctrl_d;
    logic [XLEN-1:0] hi_q, lo_q, opnd_q;
    logic [CNT_W-1:0] cnt_q, cnt_init;

    logic            accept, eff_word, sgn1, sgn2, neg1, neg2, neg_res;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] a1, a2, m1, m2, div_init, fast_raw, fast_res;

    assign in_ready  = !flush && (state_q == MD_IDLE || (state_q == MD_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == MD_DONE);
    assign busy      = (state_q != MD_IDLE);

    // Operand preparation: extend at the effective width, then take magnitudes.
    always_comb begin
        eff_word = word && (op == MD_MUL || op_is_div(op));
        sgn1     = src1_signed(op);
        sgn2     = src2_signed(op);
        a1       = src1;
        a2       = src2;
        if (eff_word) begin
            a1 = sgn1 ? sext_w(src1[31:0]) : XLEN'(src1[31:0]);
            a2 = sgn2 ? sext_w(src2[31:0]) : XLEN'(src2[31:0]);
        end
        neg1     = sgn1 && a1[XLEN-1];
        neg2     = sgn2 && a2[XLEN-1];
        m1       = neg1 ? -a1 : a1;
        m2       = neg2 ? -a2 : a2;
        neg_res  = (op_is_rem(op) || op == MD_MULHSU) ? neg1 : (neg1 ^ neg2);

        div_zero = op_is_div(op) && (a2 == '0);
        div_ovf  = op_is_div(op) && sgn1 && (a2 == '1)
                   && (a1 == (eff_word ? sext_w(32'h8000_0000) : MIN_X));
        fast     = div_zero || div_ovf;
        if (div_zero) fast_raw = op_is_rem(op) ? a1 : '1;
        else          fast_raw = op_is_rem(op) ? '0 : a1;
        fast_res = eff_word ? sext_w(fast_raw[31:0]) : fast_raw;

        // Word divides pre-shift the dividend so the top bit always enters first.
        div_init = eff_word ? (m1 << (XLEN - WORD_BITS)) : m1;
        cnt_init = eff_word ? CNT_W'(WORD_BITS / STEP_BITS) : CNT_W'(XLEN / STEP_BITS);

        ctrl_d      = '0;
        ctrl_d.op   = op;
        ctrl_d.word = eff_word;
        ctrl_d.neg  = neg_res;
    end

    // Shift-add multiply: {hi, lo} is the 2W accumulator, lo starts as the multiplier.
    logic [XLEN-1:0] mhi, mlo;
    logic [XLEN:0]   msum;

    always_comb begin
        mhi  = hi_q;
        mlo  = lo_q;
        msum = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            msum       = {1'b0, mhi} + (mlo[0] ? {1'b0, opnd_q} : '0);
            {mhi, mlo} = {msum, mlo[XLEN-1:1]};
        end
    end

    logic [XLEN-1:0] dhi, dlo;

    execute_muldiv_divstep #(
        .XLEN      (XLEN),
        .STEP_BITS (STEP_BITS)
    ) u_divstep (
        .rem_in  (hi_q),
        .quo_in  (lo_q),
        .divisor (opnd_q),
        .rem_out (dhi),
        .quo_out (dlo)
    );

    logic [XLEN-1:0]   step_hi, step_lo, quo, rem, calc_raw, calc_res;
    logic [2*XLEN-1:0] prod, prod_sh;

    // Word multiplies run W steps only, so the product sits XLEN-32 bits up.
    always_comb begin
        step_hi = op_is_div(ctrl_q.op) ? dhi : mhi;
        step_lo = op_is_div(ctrl_q.op) ? dlo : mlo;
        prod    = ctrl_q.neg ? -{mhi, mlo} : {mhi, mlo};
        prod_sh = ctrl_q.word ? (prod >> (XLEN - WORD_BITS)) : prod;
        quo     = ctrl_q.neg ? -dlo : dlo;
        rem     = ctrl_q.neg ? -dhi : dhi;
        case (ctrl_q.op)
            MD_MUL:                       calc_raw = prod_sh[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: calc_raw = prod_sh[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              calc_raw = quo;
            default:                      calc_raw = rem;
        endcase
        calc_res = ctrl_q.word ? sext_w(calc_raw[31:0]) : calc_raw;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= MD_IDLE;
            ctrl_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
            result  <= '0;
        end else if (flush) begin
            state_q <= MD_IDLE;
        end else begin
            case (state_q)
                MD_CALC: begin
                    hi_q  <= step_hi;
                    lo_q  <= step_lo;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        result  <= calc_res;
                        state_q <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    if (out_ready && !in_valid) state_q <= MD_IDLE;
                end
                default: ;
            endcase
            // Accept is only possible from IDLE or a consumed DONE, so it overrides the above.
            if (accept) begin
                ctrl_q <= ctrl_d;
                opnd_q <= op_is_div(op) ? m2 : m1;
                hi_q   <= '0;
                lo_q   <= op_is_div(op) ? div_init : m2;
                cnt_q  <= cnt_init;
                if (fast) begin
                    result  <= fast_res;
                    state_q <= MD_DONE;
                end else begin
                    state_q <= MD_CALC;
                end
            end
        end
    end

endmodule
